// File: rtl/sar_search8_pkg.sv
`default_nettype none
//============================================================================
// Package  : sar_pkg
// Brief    : Shared types and constants for the successive-approximation
//            search controller (state encoding, default width, index width).
// Revision : 1.0 - initial release
//============================================================================
package sar_pkg;

    // Default bit width of target, trial and result
    localparam int c_SAR_WIDTH = 8;

    // Index counter width for a given data width (at least one bit)
    function automatic int sar_idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int c_SAR_IDX_W = sar_idx_width(c_SAR_WIDTH);

    // Controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } sar_state_t;

endpackage : sar_pkg
`default_nettype wire

// File: rtl/sar_search8.sv
`default_nettype none
//============================================================================
// Module   : sar_search8
// Brief    : Successive-approximation search controller. Drives one trial
//            per clock (MSB first) into a magnitude comparator, consumes its
//            lt/et/gt flags, exits early on equality and finishes with a
//            verify compare of the accumulated value.
// Options  : CMP_CHECK_EN - flag the comparator when its flags are not
//            exactly one-hot (err output); otherwise err is tied low.
// Revision : 1.0 - initial release
//============================================================================
module sar_search8
    import sar_pkg::*;
#(
    parameter int WIDTH = c_SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] trial,
    input  logic             cmp_lt,
    input  logic             cmp_et,
    input  logic             cmp_gt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int                 c_IDX_W   = sar_idx_width(WIDTH);
    localparam logic [c_IDX_W-1:0] c_IDX_MSB = c_IDX_W'(WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);
    localparam logic [WIDTH-1:0]   c_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0]   c_MSB_ONE = c_ONE << (WIDTH - 1);

    sar_state_t         r_state,  w_state_nxt;
    logic [WIDTH-1:0]   r_trial,  w_trial_nxt;
    logic [WIDTH-1:0]   r_acc,    w_acc_nxt;
    logic [WIDTH-1:0]   r_result, w_result_nxt;
    logic [c_IDX_W-1:0] r_idx,    w_idx_nxt;
    logic               r_found,  w_found_nxt;
    logic [WIDTH-1:0]   w_nacc;

    // Accumulator candidate: keep the trial bit when the target lies above it
    assign w_nacc = cmp_gt ? r_trial : r_acc;

`ifdef CMP_CHECK_EN
    logic r_err, w_err_nxt;
    logic w_flags_ok;

    // Exactly one flag set: odd parity and not all three
    assign w_flags_ok = (cmp_lt ^ cmp_et ^ cmp_gt) & ~(cmp_lt & cmp_et & cmp_gt);
    assign err        = r_err;
`else
    assign err        = 1'b0;
`endif

    // Next-state and next-datapath decode
    always_comb begin
        w_state_nxt  = r_state;
        w_trial_nxt  = r_trial;
        w_acc_nxt    = r_acc;
        w_result_nxt = r_result;
        w_idx_nxt    = r_idx;
        w_found_nxt  = r_found;
`ifdef CMP_CHECK_EN
        w_err_nxt    = r_err;
`endif
        case (r_state)
            IDLE: begin
                w_trial_nxt = '0;
                if (start) begin
                    w_acc_nxt   = '0;
                    w_idx_nxt   = c_IDX_MSB;
                    w_trial_nxt = c_MSB_ONE;
                    w_found_nxt = 1'b0;
`ifdef CMP_CHECK_EN
                    w_err_nxt   = 1'b0;
`endif
                    w_state_nxt = SEARCH;
                end
            end
            SEARCH: begin
`ifdef CMP_CHECK_EN
                if (!w_flags_ok) begin
                    w_err_nxt    = 1'b1;
                    w_found_nxt  = 1'b0;
                    w_result_nxt = r_acc;
                    w_state_nxt  = DONE;
                end else
`endif
                if (cmp_et) begin
                    w_result_nxt = r_trial;
                    w_found_nxt  = 1'b1;
                    w_state_nxt  = DONE;
                end else begin
                    w_acc_nxt = w_nacc;
                    if (r_idx == '0) begin
                        w_trial_nxt = w_nacc;
                        w_state_nxt = VERIFY;
                    end else begin
                        w_idx_nxt   = r_idx - c_IDX_ONE;
                        w_trial_nxt = w_nacc | (c_ONE << (r_idx - c_IDX_ONE));
                    end
                end
            end
            VERIFY: begin
                w_result_nxt = r_acc;
                w_state_nxt  = DONE;
`ifdef CMP_CHECK_EN
                if (!w_flags_ok) begin
                    w_err_nxt   = 1'b1;
                    w_found_nxt = 1'b0;
                end else
`endif
                w_found_nxt = cmp_et;
            end
            DONE: begin
                w_trial_nxt = '0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_trial_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_trial  <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_idx    <= c_IDX_MSB;
            r_found  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_trial  <= w_trial_nxt;
            r_acc    <= w_acc_nxt;
            r_result <= w_result_nxt;
            r_idx    <= w_idx_nxt;
            r_found  <= w_found_nxt;
        end
    end

`ifdef CMP_CHECK_EN
    // Comparator fault flag, held until the next accepted start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end
`endif

    assign trial  = r_trial;
    assign result = r_result;
    assign found  = r_found;
    assign busy   = (r_state == SEARCH) || (r_state == VERIFY);
    assign done   = (r_state == DONE);

endmodule : sar_search8
`default_nettype wire

// File: tb/tb_sar_search8.sv
`default_nettype none
//============================================================================
// Module   : tb_sar_search8
// Brief    : Self-checking bench for sar_search8. A behavioural comparator
//            responds with p = target, q = trial; a binary-search reference
//            model predicts every trial, the result and the done timing.
// Options  : CMP_CHECK_EN - expectations follow the flag-checking build.
// Revision : 1.0 - initial release
//============================================================================
module tb_sar_search8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] trial;
    logic       cmp_lt, cmp_et, cmp_gt;
    logic       busy, done, found, err;
    logic [7:0] result;

    logic [7:0] target;
    logic       ovr_en, ovr_lt, ovr_et, ovr_gt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference expectations
    logic [7:0] exp_tr [16];
    int         exp_n;
    logic [7:0] exp_res;
    logic       exp_found;
    logic       exp_err;

    always #5 clk = ~clk;

    // Behavioural comparator, with an override to inject bad flag patterns
    assign cmp_lt = ovr_en ? ovr_lt : (target <  trial);
    assign cmp_et = ovr_en ? ovr_et : (target == trial);
    assign cmp_gt = ovr_en ? ovr_gt : (target >  trial);

    sar_search8 #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .trial  (trial),
        .cmp_lt (cmp_lt),
        .cmp_et (cmp_et),
        .cmp_gt (cmp_gt),
        .busy   (busy),
        .done   (done),
        .result (result),
        .found  (found),
        .err    (err)
    );

    // Binary search over the target: try each bit MSB first, keep it when
    // the target is at or above the trial, stop as soon as a trial matches.
    // Trial number n (1-based) sees chg_tgt once n > chg_k.
    task automatic ref_model(input logic [7:0] tgt, input int fault_k,
                             input int chg_k, input logic [7:0] chg_tgt);
        int   acc;
        int   t;
        int   tv;
        bit   fin;
        acc = 0; fin = 0; exp_n = 0; exp_err = 0;
        for (int b = 7; b >= 0 && !fin; b--) begin
            t = acc + (1 << b);
            exp_tr[exp_n] = 8'(t);
            exp_n++;
            tv = (exp_n > chg_k) ? int'(chg_tgt) : int'(tgt);
            if (exp_n == fault_k) begin
`ifdef CMP_CHECK_EN
                exp_res = 8'(acc); exp_found = 0; exp_err = 1; fin = 1;
`else
                acc = t;
`endif
            end else if (t == tv) begin
                exp_res = 8'(t); exp_found = 1; fin = 1;
            end else if (tv > t) begin
                acc = t;
            end
        end
        if (!fin) begin
            exp_tr[exp_n] = 8'(acc);
            exp_n++;
            tv = (exp_n > chg_k) ? int'(chg_tgt) : int'(tgt);
            exp_res   = 8'(acc);
            exp_found = (acc == tv);
        end
    endtask

    // One full search from IDLE: start, per-cycle trial/busy, done pulse, IDLE
    task automatic run_search(input string name, input logic [7:0] tgt,
                              input int fault_k, input int chg_k,
                              input logic [7:0] chg_tgt, input int pulse_k,
                              input bit hold);
        ref_model(tgt, fault_k, chg_k, chg_tgt);
        target = tgt;
        start  = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int i = 0; i < exp_n; i++) begin
            if (i + 1 > chg_k) target = chg_tgt;
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0 || trial !== exp_tr[i]) begin
                n_errors++;
                $display("FAIL %s trial%0d: trial=%h busy=%b done=%b, expected trial=%h busy=1 done=0",
                         name, i + 1, trial, busy, done, exp_tr[i]);
            end
            if (i + 1 == fault_k) begin
                ovr_en = 1'b1; ovr_lt = 1'b1; ovr_gt = 1'b1; ovr_et = 1'b0;
            end
            if (i == pulse_k) start = 1'b1;
            @(posedge clk); #1;
            ovr_en = 1'b0;
            if (i == pulse_k) start = 1'b0;
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== exp_res ||
            found !== exp_found || err !== exp_err) begin
            n_errors++;
            $display("FAIL %s done: done=%b busy=%b result=%h found=%b err=%b, expected done=1 busy=0 result=%h found=%b err=%b",
                     name, done, busy, result, found, err, exp_res, exp_found, exp_err);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || trial !== 8'h00 ||
            result !== exp_res || found !== exp_found || err !== exp_err) begin
            n_errors++;
            $display("FAIL %s idle: done=%b busy=%b trial=%h result=%h found=%b err=%b, expected 0 0 00 %h %b %b",
                     name, done, busy, trial, result, found, err, exp_res, exp_found, exp_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; target = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (trial !== 8'h00 || result !== 8'h00 || busy !== 1'b0 ||
            done !== 1'b0 || found !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: trial=%h result=%h busy=%b done=%b found=%b err=%b, expected all zero",
                     trial, result, busy, done, found, err);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_search("tgt_A5", 8'hA5, 0, 99, 8'h00, -1, 0);
        run_search("tgt_80", 8'h80, 0, 99, 8'h00, -1, 0);
        run_search("tgt_00", 8'h00, 0, 99, 8'h00, -1, 0);
        run_search("tgt_FF", 8'hFF, 0, 99, 8'h00, -1, 0);
        run_search("tgt_01", 8'h01, 0, 99, 8'h00, -1, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++)
            run_search("random", 8'($urandom_range(0, 255)), 0, 99, 8'h00, -1, 0);
    endtask

    task automatic test_target_change();
        // Target moves from 00 to 10 before the verify compare; a start
        // pulse during the search must not disturb anything.
        run_search("tgt_change", 8'h00, 0, 8, 8'h10, 3, 0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_start_ignored: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_midsearch();
        target = 8'hFF;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (trial !== 8'h00 || result !== 8'h00 || busy !== 1'b0 ||
            done !== 1'b0 || found !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: trial=%h result=%h busy=%b done=%b found=%b err=%b, expected all zero",
                     trial, result, busy, done, found, err);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_mid_quiet: cycle %0d done=%b busy=%b, expected 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_flag_fault();
        // lt and gt both asserted on the third trial
        run_search("flag_fault", 8'hA5, 3, 99, 8'h00, -1, 0);
        // A clean search afterwards clears err and finds the target
        run_search("after_fault", 8'h3C, 0, 99, 8'h00, -1, 0);
    endtask

    task automatic test_back_to_back();
        // start held high: each IDLE entry immediately restarts
        run_search("b2b_1", 8'h6D, 0, 99, 8'h00, -1, 1);
        run_search("b2b_2", 8'h00, 0, 99, 8'h00, -1, 1);
        run_search("b2b_3", 8'hC3, 0, 99, 8'h00, -1, 0);
    endtask

    initial begin
        start  = 1'b0;
        rst_n  = 1'b0;
        target = 8'h00;
        ovr_en = 1'b0; ovr_lt = 1'b0; ovr_et = 1'b0; ovr_gt = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_target_change();
        test_reset_midsearch();
        test_flag_fault();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sar_search8
`default_nettype wire
